// File: rtl/fir_decim_fifo.sv
// Decimating FWFT buffer behind the FIR stage: keeps every DECIM-th beat plus the
// tlast beat and absorbs sink backpressure, dropping (and flagging) beats when full.
module fir_decim_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PHASE_W-1:0] phase;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic keep;
  logic full;
  logic pop;
  logic wr_en;
  logic drop;

  // The upstream FIR never stalls, so this side always accepts.
  assign s_axis_tready = 1'b1;

  assign keep  = s_axis_tvalid && ((phase == '0) || s_axis_tlast);
  assign full  = (level == LEVEL_FULL);
  assign pop   = m_axis_tvalid && m_axis_tready;
  assign wr_en = keep && (!full || pop);
  assign drop  = keep && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (s_axis_tvalid) begin
      if (s_axis_tlast || (phase == PHASE_LAST)) phase <= '0;
      else                                       phase <= phase + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; level gates visibility of every entry,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{last: s_axis_tlast, data: s_axis_tdata};
  end

  // A new drop wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign m_axis_tvalid = (level != '0);
  assign m_axis_tdata  = mem[rd_ptr].data;
  assign m_axis_tlast  = mem[rd_ptr].last;

endmodule
